// File: rtl/eth_pkg.sv
// Shared Ethernet datapath definitions: wire constants, CRC-32 parameters,
// FIFO word layout and the transmit state encoding.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int WORD_W         = 9;
  localparam int WORD_VALID_BIT = 8;
  localparam int WORD_DATA_MSB  = 7;

  typedef enum logic [3:0] {
    TX_IDLE,
    TX_PRE,
    TX_SFD,
    TX_DATA,
    TX_PAD,
    TX_FCS,
    TX_ABORT,
    TX_DRAIN,
    TX_IFG
  } tx_state_e;

  // Byte idx of a 32-bit CRC word, LSB first as it goes on the wire.
  function automatic logic [7:0] crc_byte(input logic [31:0] crc, input logic [1:0] idx);
    return crc[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte (reflected form).
// Shared with the receive-side FCS checker.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_R) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_engine.sv
// GMII transmit engine: FIFO frame words in, preamble/SFD/payload/pad/FCS/IFG out.
// Outputs are registered, so each state computes the byte for the next wire cycle.
//   state    | meaning
//   TX_IDLE  | wait for a frame head; stray delimiters are popped and dropped
//   TX_PRE   | remaining preamble bytes (the first is launched from IDLE)
//   TX_SFD   | SFD byte; CRC and byte count restart
//   TX_DATA  | one FIFO word per cycle; delimiter launches first pad/FCS byte
//   TX_PAD   | zero bytes up to MIN_LEN, then FCS byte 0
//   TX_FCS   | FCS bytes 1..3
//   TX_ABORT | underrun: raw CRC bytes 1..3 so the frame fails its check
//   TX_DRAIN | discard words up to and including the delimiter
//   TX_IFG   | inter-frame gap
module gmii_tx_engine
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12,
  parameter int PRE_LEN = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [8:0]  rd_data,
  input  logic        rd_empty,
  output logic        rd_en,
  output logic        phy_tx_en,
  output logic [7:0]  phy_txd,
  output logic        busy,
  output logic [31:0] frame_cnt,
  output logic [15:0] underrun_cnt
);

  localparam logic [15:0] PRE_LOAD = 16'(PRE_LEN - 2);
  localparam logic [15:0] IFG_LOAD = 16'(IFG_LEN - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  idx_q, idx_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  logic        pop;
  logic        word_valid;
  logic [7:0]  word_byte;
  logic [7:0]  crc_data;
  logic [31:0] crc_next;
  logic [10:0] byte_cnt_inc;

  assign word_valid   = rd_data[WORD_VALID_BIT];
  assign word_byte    = rd_data[WORD_DATA_MSB:0];
  assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

  // Pad bytes (including the one launched by a short frame's delimiter) feed zeros.
  assign crc_data = (state_q == TX_DATA && word_valid) ? word_byte : 8'h00;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (crc_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    byte_cnt_d     = byte_cnt_q;
    crc_d          = crc_q;
    idx_d          = idx_q;
    tx_en_d        = 1'b0;
    txd_d          = 8'h00;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    pop            = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (!rd_empty) begin
          if (word_valid) begin
            tx_en_d = 1'b1;
            txd_d   = ETH_PREAMBLE;
            cnt_d   = PRE_LOAD;
            state_d = (PRE_LEN > 1) ? TX_PRE : TX_SFD;
          end else begin
            pop = 1'b1;
          end
        end
      end
      TX_PRE: begin
        tx_en_d = 1'b1;
        txd_d   = ETH_PREAMBLE;
        if (cnt_q == 16'd0) state_d = TX_SFD;
        else                cnt_d   = cnt_q - 16'd1;
      end
      TX_SFD: begin
        tx_en_d    = 1'b1;
        txd_d      = ETH_SFD;
        crc_d      = CRC32_INIT;
        byte_cnt_d = 11'd0;
        state_d    = TX_DATA;
      end
      TX_DATA: begin
        tx_en_d = 1'b1;
        if (rd_empty) begin
          txd_d   = crc_byte(crc_q, 2'd0);
          idx_d   = 2'd1;
          state_d = TX_ABORT;
        end else begin
          pop = 1'b1;
          if (word_valid) begin
            txd_d      = word_byte;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
          end else if (byte_cnt_q < MIN_CNT) begin
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc;
            state_d    = TX_PAD;
          end else begin
            txd_d   = crc_byte(~crc_q, 2'd0);
            idx_d   = 2'd1;
            state_d = TX_FCS;
          end
        end
      end
      TX_PAD: begin
        tx_en_d = 1'b1;
        if (byte_cnt_q < MIN_CNT) begin
          crc_d      = crc_next;
          byte_cnt_d = byte_cnt_inc;
        end else begin
          txd_d   = crc_byte(~crc_q, 2'd0);
          idx_d   = 2'd1;
          state_d = TX_FCS;
        end
      end
      TX_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = crc_byte(~crc_q, idx_q);
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          cnt_d       = IFG_LOAD;
          state_d     = TX_IFG;
        end
      end
      TX_ABORT: begin
        tx_en_d = 1'b1;
        txd_d   = crc_byte(crc_q, idx_q);
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
          state_d = TX_DRAIN;
        end
      end
      TX_DRAIN: begin
        if (!rd_empty) begin
          pop = 1'b1;
          if (!word_valid) begin
            cnt_d   = IFG_LOAD;
            state_d = TX_IFG;
          end
        end
      end
      TX_IFG: begin
        if (cnt_q == 16'd0) state_d = TX_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= TX_IDLE;
      cnt_q          <= '0;
      byte_cnt_q     <= '0;
      crc_q          <= CRC32_INIT;
      idx_q          <= '0;
      tx_en_q        <= 1'b0;
      txd_q          <= 8'h00;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      crc_q          <= crc_d;
      idx_q          <= idx_d;
      tx_en_q        <= tx_en_d;
      txd_q          <= txd_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign rd_en        = pop & ~sys_rst;
  assign phy_tx_en    = tx_en_q;
  assign phy_txd      = txd_q;
  assign busy         = (state_q != TX_IDLE);
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_gmii_tx_engine.sv
// Bench for gmii_tx_engine: queue-based FIFO and wire recorder, frames checked
// against a table-driven CRC model of the expected wire image.
module tb_gmii_tx_engine;
  import eth_pkg::*;

  localparam int MIN_LEN = 60;
  localparam int IFG_LEN = 12;
  localparam int PRE_LEN = 7;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [8:0]  rd_data = 9'h000;
  logic        rd_empty = 1'b1;
  logic        rd_en;
  logic        phy_tx_en;
  logic [7:0]  phy_txd;
  logic        busy;
  logic [31:0] frame_cnt;
  logic [15:0] underrun_cnt;

  gmii_tx_engine #(.MIN_LEN(MIN_LEN), .IFG_LEN(IFG_LEN), .PRE_LEN(PRE_LEN)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .rd_en        (rd_en),
    .phy_tx_en    (phy_tx_en),
    .phy_txd      (phy_txd),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #4 sys_clk = ~sys_clk;

  logic [8:0]  fifo_q[$];
  logic [8:0]  trace_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  burst_q[$];
  logic [31:0] crc_tab[256];
  logic [31:0] exp_fcs;
  int          burst_start, burst_end;
  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  logic        pop_req = 1'b0;

  // FWFT FIFO model: pop decision sampled mid-cycle, applied just after the edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      pop_req = rd_en;
      @(posedge sys_clk);
      #1;
      if (sys_rst) fifo_q.delete();
      else if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rd_empty = (fifo_q.size() == 0);
      rd_data  = rd_empty ? 9'h000 : fifo_q[0];
    end
  end

  always @(negedge sys_clk) begin
    trace_q.push_back({phy_tx_en, phy_txd});
    if (rd_en && rd_empty) viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] ix;
    ix = c[7:0] ^ b;
    return (c >> 8) ^ crc_tab[ix];
  endfunction

  task automatic build_tab();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  task automatic make_pay(input int n, input bit ramp);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(ramp ? 8'(i) : 8'($urandom));
  endtask

  // Expected wire image; an aborted frame ends in the raw (non-inverted) CRC.
  task automatic build_exp(input bit abort);
    logic [31:0] c;
    exp_q.delete();
    repeat (PRE_LEN) exp_q.push_back(ETH_PREAMBLE);
    exp_q.push_back(ETH_SFD);
    c = CRC32_INIT;
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      c = crc_upd(c, pay_q[i]);
    end
    if (!abort) begin
      for (int i = pay_q.size(); i < MIN_LEN; i++) begin
        exp_q.push_back(8'h00);
        c = crc_upd(c, 8'h00);
      end
      c = ~c;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    exp_fcs = c;
  endtask

  task automatic push_frame(input bit with_delim);
    foreach (pay_q[i]) fifo_q.push_back({1'b1, pay_q[i]});
    if (with_delim) fifo_q.push_back({1'b0, 8'($urandom)});
  endtask

  task automatic find_burst(input int k);
    int n;
    n = -1;
    burst_q.delete();
    burst_start = -1;
    burst_end = -1;
    for (int i = 0; i < trace_q.size(); i++) begin
      if (trace_q[i][8] && (i == 0 || !trace_q[i-1][8])) n++;
      if (trace_q[i][8] && n == k) begin
        if (burst_start < 0) burst_start = i;
        burst_end = i;
        burst_q.push_back(trace_q[i][7:0]);
      end
    end
  endtask

  function automatic int count_bursts();
    int n;
    n = 0;
    for (int i = 0; i < trace_q.size(); i++)
      if (trace_q[i][8] && (i == 0 || !trace_q[i-1][8])) n++;
    return n;
  endfunction

  task automatic wait_quiet(input string tag, input int max);
    int i;
    i = 0;
    while ((busy || fifo_q.size() != 0) && i < max) begin
      tick(1);
      i++;
    end
    check({tag, " done in budget"}, 64'(i < max), 64'd1);
  endtask

  task automatic cmp_frame(input string tag, input int k);
    int mism;
    mism = 0;
    find_burst(k);
    check({tag, " len"}, 64'(burst_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < burst_q.size(); i++)
      if (burst_q[i] !== exp_q[i]) mism++;
    check({tag, " bytes"}, 64'(mism), 64'd0);
  endtask

  initial begin
    logic [31:0] c;
    logic [31:0] fcs_seen;
    int len0, len1, i;

    build_tab();

    // Reset state
    sys_rst = 1'b1;
    tick(3);
    check("rst tx_en", 64'(phy_tx_en), 64'd0);
    check("rst txd", 64'(phy_txd), 64'h00);
    check("rst busy", 64'(busy), 64'd0);
    check("rst rd_en", 64'(rd_en), 64'd0);
    check("rst frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst underrun_cnt", 64'(underrun_cnt), 64'd0);
    sys_rst = 1'b0;
    tick(2);

    // 14-byte ramp frame, padded
    trace_q.delete();
    make_pay(14, 1'b1);
    build_exp(1'b0);
    push_frame(1'b1);
    wait_quiet("f14", 600);
    cmp_frame("f14", 0);
    check("f14 tx_en cycles", 64'(burst_q.size()), 64'd72);
    c = CRC32_INIT;
    for (int k = PRE_LEN + 1; k < burst_q.size(); k++) c = crc_upd(c, burst_q[k]);
    check("f14 residue", 64'(c), 64'(CRC32_RESIDUE));
    check("f14 frame_cnt", 64'(frame_cnt), 64'd1);

    // 64-byte random frame, no pad
    trace_q.delete();
    make_pay(64, 1'b0);
    build_exp(1'b0);
    push_frame(1'b1);
    wait_quiet("f64", 600);
    cmp_frame("f64", 0);
    check("f64 tx_en cycles", 64'(burst_q.size()), 64'd76);
    fcs_seen = 32'h0;
    if (burst_q.size() >= 4)
      fcs_seen = {burst_q[burst_q.size()-1], burst_q[burst_q.size()-2],
                  burst_q[burst_q.size()-3], burst_q[burst_q.size()-4]};
    check("f64 fcs", 64'(fcs_seen), 64'(exp_fcs));
    check("f64 frame_cnt", 64'(frame_cnt), 64'd2);

    // Random lengths around the pad boundary
    for (int f = 0; f < 4; f++) begin
      trace_q.delete();
      make_pay($urandom_range(1, 120), 1'b0);
      if (f == 0) make_pay(MIN_LEN - 1, 1'b0);
      if (f == 1) make_pay(MIN_LEN, 1'b0);
      build_exp(1'b0);
      push_frame(1'b1);
      wait_quiet("rnd", 800);
      cmp_frame($sformatf("rnd%0d", f), 0);
    end
    check("rnd frame_cnt", 64'(frame_cnt), 64'd6);

    // Back-to-back frames
    trace_q.delete();
    len0 = $urandom_range(5, 40);
    len1 = $urandom_range(61, 90);
    make_pay(len0, 1'b0);
    push_frame(1'b1);
    build_exp(1'b0);
    begin
      logic [7:0] exp0_q[$];
      exp0_q = exp_q;
      make_pay(len1, 1'b0);
      push_frame(1'b1);
      wait_quiet("b2b", 1000);
      check("b2b bursts", 64'(count_bursts()), 64'd2);
      find_burst(0);
      len0 = burst_end;
      i = 0;
      for (int k = 0; k < exp0_q.size() && k < burst_q.size(); k++)
        if (burst_q[k] !== exp0_q[k]) i++;
      check("b2b frame0 len", 64'(burst_q.size()), 64'(exp0_q.size()));
      check("b2b frame0 bytes", 64'(i), 64'd0);
    end
    build_exp(1'b0);
    cmp_frame("b2b frame1", 1);
    check("b2b gap", 64'(burst_start - len0 - 1), 64'(IFG_LEN));
    check("b2b frame_cnt", 64'(frame_cnt), 64'd8);

    // Underrun after 20 bytes, then the tail arrives and is drained
    trace_q.delete();
    make_pay(20, 1'b0);
    build_exp(1'b1);
    push_frame(1'b0);
    tick(60);
    cmp_frame("underrun", 0);
    check("underrun busy in drain", 64'(busy), 64'd1);
    check("underrun_cnt", 64'(underrun_cnt), 64'd1);
    check("underrun frame_cnt", 64'(frame_cnt), 64'd8);
    make_pay(5, 1'b0);
    push_frame(1'b1);
    wait_quiet("drain", 200);
    check("drain no tx", 64'(count_bursts()), 64'd1);
    check("drain fifo empty", 64'(fifo_q.size()), 64'd0);
    check("drain underrun_cnt", 64'(underrun_cnt), 64'd1);

    // Lone delimiter at the head in IDLE
    trace_q.delete();
    fifo_q.push_back({1'b0, 8'($urandom)});
    tick(5);
    check("lone popped", 64'(fifo_q.size()), 64'd0);
    check("lone no tx", 64'(count_bursts()), 64'd0);
    check("lone busy", 64'(busy), 64'd0);
    make_pay(30, 1'b0);
    build_exp(1'b0);
    push_frame(1'b1);
    wait_quiet("after lone", 600);
    check("after lone bursts", 64'(count_bursts()), 64'd1);
    cmp_frame("after lone", 0);
    check("after lone frame_cnt", 64'(frame_cnt), 64'd9);

    // Reset during payload byte 30
    trace_q.delete();
    make_pay(50, 1'b0);
    push_frame(1'b1);
    i = 0;
    while (!phy_tx_en && i < 50) begin
      tick(1);
      i++;
    end
    check("mid rst start seen", 64'(i < 50), 64'd1);
    tick(PRE_LEN + 1 + 29);
    check("mid rst byte30 on wire", 64'(phy_txd), 64'(pay_q[29]));
    sys_rst = 1'b1;
    tick(1);
    check("mid rst tx_en", 64'(phy_tx_en), 64'd0);
    check("mid rst txd", 64'(phy_txd), 64'h00);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst frame_cnt", 64'(frame_cnt), 64'd0);
    check("mid rst underrun_cnt", 64'(underrun_cnt), 64'd0);
    sys_rst = 1'b0;
    tick(2);

    trace_q.delete();
    make_pay(5, 1'b0);
    build_exp(1'b0);
    push_frame(1'b1);
    wait_quiet("post rst", 600);
    cmp_frame("post rst", 0);
    check("post rst frame_cnt", 64'(frame_cnt), 64'd1);

    check("rd_en while empty", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
